// File: rtl/raptor64_bcd_seq_pkg.sv
// Shared encodings for the wide packed-BCD sequencer: FSM states and op select.
package raptor64_bcd_seq_pkg;
  typedef enum logic [1:0] {
    BCDS_IDLE = 2'd0,
    BCDS_RUN  = 2'd1,
    BCDS_DONE = 2'd2
  } bcds_state_e;

  localparam logic BCDOP_ADD = 1'b0;
  localparam logic BCDOP_SUB = 1'b1;
endpackage

// File: rtl/raptor64_bcd_seq_cells.sv
// Two-digit packed-BCD add and subtract cells with decimal carry/borrow in and out.
module BCDAdd (
  input  logic       ci,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] o,
  output logic       c
);
  logic [4:0] s0, s1;
  logic       c0;
  always_comb begin
    s0 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, ci};
    c0 = (s0 > 5'd9);
    if (c0) s0 = s0 + 5'd6;
    s1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, c0};
    c  = (s1 > 5'd9);
    if (c) s1 = s1 + 5'd6;
    o  = {s1[3:0], s0[3:0]};
  end
endmodule

module BCDSub (
  input  logic       ci,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] o,
  output logic       c
);
  logic [4:0] d0, d1;
  logic       c0;
  always_comb begin
    // the 5-bit difference is two's complement; bit 4 is the digit borrow
    d0 = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, ci};
    c0 = d0[4];
    if (c0) d0 = d0 + 5'd10;
    d1 = {1'b0, a[7:4]} - {1'b0, b[7:4]} - {4'd0, c0};
    c  = d1[4];
    if (c) d1 = d1 + 5'd10;
    o  = {d1[3:0], d0[3:0]};
  end
endmodule

// File: rtl/raptor64_bcd_seq.sv
// Byte-serial packed-BCD add/subtract sequencer built on one BCDAdd and one BCDSub cell.
// Optional digit validity check enabled by defining RAPTOR64_BCD_CHECK_EN.
module raptor64_bcd_seq
  import raptor64_bcd_seq_pkg::*;
#(
  parameter int NBYTES = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                op_i,
  input  logic [8*NBYTES-1:0] a_i,
  input  logic [8*NBYTES-1:0] b_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [8*NBYTES-1:0] o,
  output logic                c_o,
  output logic                err_o
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  bcds_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q, b_q, acc_q, acc_d, o_q;
  logic          op_q, cy_q, c_q;
  logic [7:0]    a_byte, b_byte, add_o, sub_o, res_byte;
  logic          add_c, sub_c, cell_c, last, accept;

  assign accept = start_i && (state_q != BCDS_RUN);
  assign last   = (cnt_q == CW'(NBYTES - 1));
  assign a_byte = a_q[8*cnt_q +: 8];
  assign b_byte = b_q[8*cnt_q +: 8];

  BCDAdd u_add (.ci(cy_q), .a(a_byte), .b(b_byte), .o(add_o), .c(add_c));
  BCDSub u_sub (.ci(cy_q), .a(a_byte), .b(b_byte), .o(sub_o), .c(sub_c));

  assign res_byte = (op_q == BCDOP_SUB) ? sub_o : add_o;
  assign cell_c   = (op_q == BCDOP_SUB) ? sub_c : add_c;

  always_comb begin
    acc_d = acc_q;
    acc_d[8*cnt_q +: 8] = res_byte;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BCDS_IDLE: if (start_i) state_d = BCDS_RUN;
      BCDS_RUN: begin
        if (abort_i)   state_d = BCDS_IDLE;
        else if (last) state_d = BCDS_DONE;
      end
      BCDS_DONE: state_d = start_i ? BCDS_RUN : BCDS_IDLE;
      default:   state_d = BCDS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BCDS_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= BCDOP_ADD;
      cy_q    <= 1'b0;
      o_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= a_i;
        b_q   <= b_i;
        op_q  <= op_i;
        cnt_q <= '0;
        cy_q  <= 1'b0;
      end else if (state_q == BCDS_RUN && !abort_i) begin
        acc_q <= acc_d;
        cy_q  <= cell_c;
        cnt_q <= cnt_q + CW'(1);
        // the visible result only moves when the final byte lands
        if (last) begin
          o_q <= acc_d;
          c_q <= cell_c;
        end
      end
    end
  end

`ifdef RAPTOR64_BCD_CHECK_EN
  logic bad_in, bad_q, err_q;
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < 2*NBYTES; i++)
      if (a_i[4*i +: 4] > 4'd9 || b_i[4*i +: 4] > 4'd9) bad_in = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      bad_q <= bad_in;
      err_q <= 1'b0;
    end else if (state_q == BCDS_RUN) begin
      if (abort_i)   err_q <= 1'b0;
      else if (last) err_q <= bad_q;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o = (state_q == BCDS_RUN);
  assign done_o = (state_q == BCDS_DONE);
  assign o      = o_q;
  assign c_o    = c_q;
endmodule
